// File: rtl/cam_pkg.sv
// Shared definitions for the camera frame-buffer write controller:
// FSM state encoding and frame geometry helpers.
package cam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_CAM  = 3'd1,
        ST_WAIT_SOF  = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_FRAME_END = 3'd4,
        ST_WAIT_FULL = 3'd5
    } cam_state_e;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam int FRAME_PIX = H_RES_DEF * V_RES_DEF;

    function automatic int frame_pix(input int h_res, input int v_res);
        return h_res * v_res;
    endfunction

endpackage

// File: rtl/cam_wr_pipe.sv
// Delay line carrying (valid, address) of accepted pixels until the camera
// data for that pixel appears; a flush squashes every in-flight write.
module cam_wr_pipe #(
    parameter int RD_LAT = 1,
    parameter int AW     = 19
) (
    input  logic          i_clk,
    input  logic          i_flush,
    input  logic          i_valid,
    input  logic [AW-1:0] i_addr,
    output logic          o_valid,
    output logic [AW-1:0] o_addr
);

    generate
        if (RD_LAT == 0) begin : g_bypass
            assign o_valid = i_valid;
            assign o_addr  = i_addr;
        end else begin : g_delay
            logic [RD_LAT-1:0] valid_q;
            logic [AW-1:0]     addr_q [RD_LAT];

            always_ff @(posedge i_clk) begin
                if (i_flush) begin
                    valid_q <= '0;
                    for (int i = 0; i < RD_LAT; i++) begin
                        addr_q[i] <= '0;
                    end
                end else begin
                    valid_q[0] <= i_valid;
                    addr_q[0]  <= i_addr;
                    for (int i = 1; i < RD_LAT; i++) begin
                        valid_q[i] <= valid_q[i-1];
                        addr_q[i]  <= addr_q[i-1];
                    end
                end
            end

            assign o_valid = valid_q[RD_LAT-1];
            assign o_addr  = addr_q[RD_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/cam_fb_write_ctrl.sv
// Captures camera pixels into a double-buffered frame buffer: aligns to SOF,
// generates write strobes/addresses, swaps banks per frame and flags errors.
module cam_fb_write_ctrl
    import cam_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int AW     = 19,
    parameter int RD_LAT = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cam_done,
    input  logic          i_sof,
    input  logic          i_start,
    input  logic          i_stop,
    input  logic          i_snapshot,
    input  logic          i_cam_data_valid,
    input  logic [11:0]   i_cam_data,
    output logic          o_data_ready,
    output logic          o_wr_en,
    output logic          o_wr_bank,
    output logic [AW-1:0] o_wr_addr,
    output logic [11:0]   o_wr_data,
    output logic          o_rd_bank,
    output logic          o_frame_done,
    output logic          o_busy,
    output logic          o_err_short,
    output logic          o_err_long
);

    localparam logic [AW-1:0] LAST_PIX = AW'(frame_pix(H_RES, V_RES) - 1);

    cam_state_e    state_q, state_d;
    logic [AW-1:0] count_q;
    logic [1:0]    drain_q;
    logic          stop_pending_q;
    logic          wr_bank_q, rd_bank_q;
    logic          frame_done_q;
    logic          err_short_q, err_long_q;

    logic          arm, capture_acc, count_clr, done_fire, set_short, set_long;
    logic          data_ready, drain_done;
    logic          pipe_valid;
    logic [AW-1:0] pipe_addr;

    // FRAME_END lasts RD_LAT cycles (at least one) so the last write leaves the pipe first
    assign drain_done = (int'(drain_q) >= RD_LAT - 1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        arm         = 1'b0;
        capture_acc = 1'b0;
        count_clr   = 1'b0;
        done_fire   = 1'b0;
        set_short   = 1'b0;
        set_long    = 1'b0;
        data_ready  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    arm     = 1'b1;
                    state_d = ST_WAIT_CAM;
                end
            end
            ST_WAIT_CAM: begin
                if (i_cam_done) state_d = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                data_ready = 1'b1;
                if (i_sof) begin
                    count_clr = 1'b1;
                    state_d   = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                data_ready = 1'b1;
                if (i_sof) begin
                    set_short = 1'b1;
                    count_clr = 1'b1;
                end else if (i_cam_data_valid) begin
                    capture_acc = 1'b1;
                    if (count_q == LAST_PIX) state_d = ST_FRAME_END;
                end
            end
            ST_FRAME_END: begin
                if (drain_done) begin
                    done_fire = 1'b1;
                    state_d   = (stop_pending_q || i_stop || i_snapshot) ? ST_IDLE : ST_WAIT_FULL;
                end
            end
            ST_WAIT_FULL: begin
                data_ready = 1'b1;
                if (i_sof) begin
                    count_clr = 1'b1;
                    state_d   = ST_CAPTURE;
                end else if (i_cam_data_valid) begin
                    set_long = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q        <= '0;
            drain_q        <= '0;
            stop_pending_q <= 1'b0;
            wr_bank_q      <= 1'b0;
            rd_bank_q      <= 1'b0;
            frame_done_q   <= 1'b0;
            err_short_q    <= 1'b0;
            err_long_q     <= 1'b0;
        end else begin
            if (count_clr) begin
                count_q <= '0;
            end else if (capture_acc) begin
                count_q <= count_q + 1'b1;
            end
            drain_q      <= (state_q == ST_FRAME_END) ? drain_q + 2'd1 : 2'd0;
            frame_done_q <= done_fire;
            if (done_fire) begin
                rd_bank_q <= wr_bank_q;
                wr_bank_q <= ~wr_bank_q;
            end
            if (state_d == ST_IDLE) begin
                stop_pending_q <= 1'b0;
            end else if (i_stop && state_q != ST_IDLE) begin
                stop_pending_q <= 1'b1;
            end
            if (arm) begin
                err_short_q <= 1'b0;
                err_long_q  <= 1'b0;
            end else begin
                if (set_short) err_short_q <= 1'b1;
                if (set_long)  err_long_q  <= 1'b1;
            end
        end
    end

    cam_wr_pipe #(
        .RD_LAT (RD_LAT),
        .AW     (AW)
    ) u_pipe (
        .i_clk   (i_clk),
        .i_flush (i_rst),
        .i_valid (capture_acc && !i_rst),
        .i_addr  (count_q),
        .o_valid (pipe_valid),
        .o_addr  (pipe_addr)
    );

    assign o_data_ready = data_ready;
    assign o_wr_en      = pipe_valid;
    assign o_wr_bank    = wr_bank_q;
    assign o_wr_addr    = pipe_valid ? pipe_addr : '0;
    assign o_wr_data    = pipe_valid ? i_cam_data : 12'h000;
    assign o_rd_bank    = rd_bank_q;
    assign o_frame_done = frame_done_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_err_short  = err_short_q;
    assign o_err_long   = err_long_q;

endmodule

// File: tb/tb_cam_fb_write_ctrl.sv
// Scoreboard bench for cam_fb_write_ctrl: a 4x2 frame with RD_LAT=1 (instance a)
// and RD_LAT=2 (instance b); expected writes and frame-done pulses carry their due cycle.
module tb_cam_fb_write_ctrl;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int AW   = 3;
    localparam int NPIX = H * V;

    typedef struct {
        logic          bank;
        logic [AW-1:0] addr;
        logic [11:0]   data;
        int            cyc;
    } wr_t;

    typedef struct {
        logic rd;
        logic wr;
        int   cyc;
    } done_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, cam_done, sof, stop, snapshot;
    logic start_a, start_b, valid_a, valid_b;
    logic [11:0] pix_val;
    logic [11:0] pix_seed;
    logic [11:0] data_a  = 12'h000;
    logic [11:0] stage_b = 12'h000;
    logic [11:0] data_b  = 12'h000;

    logic          ready_a, wr_en_a, wr_bank_a, rd_bank_a, frame_done_a, busy_a, err_short_a, err_long_a;
    logic [AW-1:0] wr_addr_a;
    logic [11:0]   wr_data_a;
    logic          ready_b, wr_en_b, wr_bank_b, rd_bank_b, frame_done_b, busy_b, err_short_b, err_long_b;
    logic [AW-1:0] wr_addr_b;
    logic [11:0]   wr_data_b;

    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    int    done_cnt [2];
    logic  exp_bank [2];
    wr_t   q_a[$], q_b[$];
    done_t dq_a[$], dq_b[$];

    cam_fb_write_ctrl #(.H_RES(H), .V_RES(V), .AW(AW), .RD_LAT(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_cam_done(cam_done), .i_sof(sof), .i_start(start_a),
        .i_stop(stop), .i_snapshot(snapshot), .i_cam_data_valid(valid_a), .i_cam_data(data_a),
        .o_data_ready(ready_a), .o_wr_en(wr_en_a), .o_wr_bank(wr_bank_a), .o_wr_addr(wr_addr_a),
        .o_wr_data(wr_data_a), .o_rd_bank(rd_bank_a), .o_frame_done(frame_done_a), .o_busy(busy_a),
        .o_err_short(err_short_a), .o_err_long(err_long_a)
    );

    cam_fb_write_ctrl #(.H_RES(H), .V_RES(V), .AW(AW), .RD_LAT(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_cam_done(cam_done), .i_sof(sof), .i_start(start_b),
        .i_stop(stop), .i_snapshot(snapshot), .i_cam_data_valid(valid_b), .i_cam_data(data_b),
        .o_data_ready(ready_b), .o_wr_en(wr_en_b), .o_wr_bank(wr_bank_b), .o_wr_addr(wr_addr_b),
        .o_wr_data(wr_data_b), .o_rd_bank(rd_bank_b), .o_frame_done(frame_done_b), .o_busy(busy_b),
        .o_err_short(err_short_b), .o_err_long(err_long_b)
    );

    // Camera FIFO model: the accepted pixel shows up RD_LAT cycles later
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (valid_a && ready_a) data_a <= pix_val;
        if (valid_b && ready_b) stage_b <= pix_val;
        data_b <= stage_b;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mon_write(input int sel, input string sfx, input logic en, input logic bank,
                             input logic [AW-1:0] addr, input logic [11:0] data);
        wr_t  w;
        logic exp_en;
        if (sel == 0) exp_en = (q_a.size() > 0) && (q_a[0].cyc == cyc);
        else          exp_en = (q_b.size() > 0) && (q_b[0].cyc == cyc);
        if (en || exp_en) begin
            checkOutput({"wr_en_", sfx}, 32'(en), 32'(exp_en));
            if (exp_en) begin
                if (sel == 0) w = q_a.pop_front();
                else          w = q_b.pop_front();
                if (en) begin
                    checkOutput({"wr_bank_", sfx}, 32'(bank), 32'(w.bank));
                    checkOutput({"wr_addr_", sfx}, 32'(addr), 32'(w.addr));
                    checkOutput({"wr_data_", sfx}, 32'(data), 32'(w.data));
                end
            end
        end
    endtask

    task automatic mon_done(input int sel, input string sfx, input logic pulse, input logic rd, input logic wr);
        done_t d;
        logic  exp_p;
        if (sel == 0) exp_p = (dq_a.size() > 0) && (dq_a[0].cyc == cyc);
        else          exp_p = (dq_b.size() > 0) && (dq_b[0].cyc == cyc);
        if (pulse) done_cnt[sel]++;
        if (pulse || exp_p) begin
            checkOutput({"frame_done_", sfx}, 32'(pulse), 32'(exp_p));
            if (exp_p) begin
                if (sel == 0) d = dq_a.pop_front();
                else          d = dq_b.pop_front();
                if (pulse) begin
                    checkOutput({"done_rd_bank_", sfx}, 32'(rd), 32'(d.rd));
                    checkOutput({"done_wr_bank_", sfx}, 32'(wr), 32'(d.wr));
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon_write(0, "a", wr_en_a, wr_bank_a, wr_addr_a, wr_data_a);
        mon_write(1, "b", wr_en_b, wr_bank_b, wr_addr_b, wr_data_b);
        mon_done(0, "a", frame_done_a, rd_bank_a, wr_bank_a);
        mon_done(1, "b", frame_done_b, rd_bank_b, wr_bank_b);
    end

    // SOF pulse then n_pix back-to-back pixels; each pixel's write and the frame-done are queued
    task automatic applyStimulus(input int sel, input int n_pix);
        wr_t   w;
        done_t d;
        int    lat;
        lat = (sel == 0) ? 1 : 2;
        sof = 1'b1;
        tick(1);
        sof = 1'b0;
        for (int i = 0; i < n_pix; i++) begin
            pix_val  = pix_seed;
            pix_seed = pix_seed + 12'd1;
            if (sel == 0) valid_a = 1'b1;
            else          valid_b = 1'b1;
            w.bank = exp_bank[sel];
            w.addr = AW'(i);
            w.data = pix_val;
            w.cyc  = cyc + lat;
            if (sel == 0) q_a.push_back(w);
            else          q_b.push_back(w);
            tick(1);
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
        if (n_pix == NPIX) begin
            d.rd  = exp_bank[sel];
            d.wr  = ~exp_bank[sel];
            d.cyc = cyc + lat;
            if (sel == 0) dq_a.push_back(d);
            else          dq_b.push_back(d);
            exp_bank[sel] = ~exp_bank[sel];
        end
    endtask

    task automatic stale_pixels(input int n);
        pix_val = 12'hEEE;
        valid_a = 1'b1;
        tick(n);
        valid_a = 1'b0;
    endtask

    function automatic logic [31:0] out_vec_a();
        return 32'({ready_a, wr_en_a, wr_bank_a, wr_addr_a, wr_data_a, rd_bank_a,
                    frame_done_a, busy_a, err_short_a, err_long_a});
    endfunction

    function automatic logic [31:0] out_vec_b();
        return 32'({ready_b, wr_en_b, wr_bank_b, wr_addr_b, wr_data_b, rd_bank_b,
                    frame_done_b, busy_b, err_short_b, err_long_b});
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; cam_done = 1'b0; sof = 1'b0; stop = 1'b0; snapshot = 1'b0;
        start_a = 1'b0; start_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        pix_val = 12'h000; pix_seed = 12'h001;
        done_cnt[0] = 0; done_cnt[1] = 0;
        exp_bank[0] = 1'b0; exp_bank[1] = 1'b0;
        tick(2);
        checkOutput("reset_outputs_a", out_vec_a(), 32'h0);
        checkOutput("reset_outputs_b", out_vec_b(), 32'h0);

        // Armed but camera not ready: no pulls, busy, no writes
        rst = 1'b0; start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        tick(20);
        checkOutput("wait_cam_ready", 32'(ready_a), 32'h0);
        checkOutput("wait_cam_busy", 32'(busy_a), 32'h1);

        // Camera ready: stale FIFO data is flushed, then one frame into bank 0
        cam_done = 1'b1;
        tick(1);
        checkOutput("wait_sof_ready", 32'(ready_a), 32'h1);
        stale_pixels(2);
        applyStimulus(0, NPIX);
        tick(4);
        checkOutput("frame1_rd_bank", 32'(rd_bank_a), 32'h0);
        checkOutput("frame1_wr_bank", 32'(wr_bank_a), 32'h1);

        // Continuous capture: banks alternate
        applyStimulus(0, NPIX);
        tick(4);
        applyStimulus(0, NPIX);
        tick(4);
        checkOutput("continuous_done_cnt", 32'(done_cnt[0]), 32'd3);
        checkOutput("continuous_rd_bank", 32'(rd_bank_a), 32'h0);

        // Short frame: SOF after 5 pixels restarts the frame in the same bank
        applyStimulus(0, 5);
        tick(1);
        checkOutput("short_err_before", 32'(err_short_a), 32'h0);
        applyStimulus(0, NPIX);
        tick(4);
        checkOutput("short_err_set", 32'(err_short_a), 32'h1);
        checkOutput("short_done_cnt", 32'(done_cnt[0]), 32'd4);

        // Snapshot: one frame then back to IDLE; later pixels are not pulled
        snapshot = 1'b1;
        applyStimulus(0, NPIX);
        tick(4);
        snapshot = 1'b0;
        stale_pixels(3);
        checkOutput("snapshot_ready", 32'(ready_a), 32'h0);
        checkOutput("snapshot_busy", 32'(busy_a), 32'h0);

        // Re-arm clears errors; pixels after a full frame raise the long error
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        tick(1);
        checkOutput("start_clears_short", 32'(err_short_a), 32'h0);
        applyStimulus(0, NPIX);
        tick(4);
        checkOutput("long_err_before", 32'(err_long_a), 32'h0);
        stale_pixels(3);
        checkOutput("long_err_set", 32'(err_long_a), 32'h1);

        // Stop pulse in WAIT_FULL: the next frame completes, then IDLE
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        applyStimulus(0, NPIX);
        tick(4);
        checkOutput("stop_busy", 32'(busy_a), 32'h0);
        checkOutput("stop_long_sticky", 32'(err_long_a), 32'h1);

        // Reset in the middle of a frame squashes the in-flight write
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        tick(1);
        applyStimulus(0, 4);
        rst = 1'b1; valid_a = 1'b1; pix_val = 12'hBAD;
        tick(1);
        checkOutput("midreset_outputs_a", out_vec_a(), 32'h0);
        checkOutput("midreset_outputs_b", out_vec_b(), 32'h0);
        rst = 1'b0; valid_a = 1'b0;
        exp_bank[0] = 1'b0; exp_bank[1] = 1'b0;
        tick(3);
        checkOutput("post_reset_wr_en", 32'(wr_en_a), 32'h0);

        // RD_LAT=2 instance: same frame, writes two cycles after each accept
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        tick(1);
        applyStimulus(1, NPIX);
        tick(5);
        checkOutput("lat2_rd_bank", 32'(rd_bank_b), 32'h0);
        checkOutput("lat2_wr_bank", 32'(wr_bank_b), 32'h1);
        checkOutput("lat2_done_cnt", 32'(done_cnt[1]), 32'd1);

        checkOutput("total_done_a", 32'(done_cnt[0]), 32'd7);
        checkOutput("pending_writes_a", 32'(q_a.size()), 32'd0);
        checkOutput("pending_writes_b", 32'(q_b.size()), 32'd0);
        checkOutput("pending_done_a", 32'(dq_a.size()), 32'd0);
        checkOutput("pending_done_b", 32'(dq_b.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cam_fb_write_ctrl.md
Name: cam_fb_write_ctrl

Overview:
Sequences capture of camera pixels into a double-buffered frame buffer. Sits between the camera output handshake (valid/ready, 12-bit RGB444) and a dual-bank BRAM frame buffer. Waits for camera init done, aligns to start-of-frame, and generates write enables and addresses. Swaps banks on each complete frame and reports frame completion and errors to the video pipeline.

Parameters:
H_RES, 640, active pixels per line
V_RES, 480, active lines per frame
AW, 19, per-bank address width; must satisfy 2^AW >= H_RES*V_RES
RD_LAT, 1, cycles from accept (ready&valid) to i_cam_data holding that pixel; legal range 0..2

Ports:
i_clk  in  1  system clock; the camera FIFO read side runs on this clock
i_rst  in  1  synchronous, active-high reset
i_cam_done  in  1  camera init complete; level
i_sof  in  1  start-of-frame pulse, one cycle, already synchronized to i_clk
i_start  in  1  pulse; arm capture
i_stop  in  1  pulse; stop after the current frame completes
i_snapshot  in  1  level; 1 means capture one frame then stop
i_cam_data_valid  in  1  camera pixel available
i_cam_data  in  12  pixel, RD_LAT cycles after accept
o_data_ready  out  1  pull request to the camera FIFO
o_wr_en  out  1  frame buffer write strobe
o_wr_bank  out  1  bank being written
o_wr_addr  out  AW  write address within bank
o_wr_data  out  12  write data
o_rd_bank  out  1  last completely written bank
o_frame_done  out  1  one-cycle pulse per completed frame
o_busy  out  1  1 in any state other than IDLE
o_err_short  out  1  sticky; SOF arrived before the frame was full
o_err_long  out  1  sticky; pixels arrived after the frame was full

Behaviour:
- Reset clears every output and internal register to 0. State is IDLE, o_rd_bank=0, o_wr_bank=0. Reset mid-capture discards the partial frame, and in-flight pipeline writes are squashed.
- FSM states:
  - IDLE: waits for i_start. On i_start, go to WAIT_CAM.
  - WAIT_CAM: when i_cam_done=1, go to WAIT_SOF.
  - WAIT_SOF: o_data_ready=1 and accepted pixels are discarded, with no writes (flushes stale FIFO data). On i_sof, clear the pixel count and go to CAPTURE.
  - CAPTURE: o_data_ready=1.
    - Each accept increments count and schedules a write RD_LAT cycles later at addr=count (pre-increment).
    - When count reaches H_RES*V_RES, go to FRAME_END.
    - If i_sof arrives while count < H_RES*V_RES: set o_err_short, clear count, stay in CAPTURE with the same bank (frame restarts). No bank swap.
  - FRAME_END (o_data_ready=0): wait until pipeline writes drain (RD_LAT cycles).
    - Then pulse o_frame_done, set o_rd_bank=o_wr_bank and toggle o_wr_bank, all in the same cycle.
    - Next: go to IDLE if a stop is pending or i_snapshot=1; otherwise go to WAIT_FULL.
  - WAIT_FULL: o_data_ready=1, pixels discarded. Any accept here sets o_err_long. On i_sof, go to CAPTURE with count cleared.
- Write pipeline: a shift register of depth RD_LAT carries (valid, addr). o_wr_en, o_wr_addr and o_wr_data are driven combinationally from the pipeline tail and i_cam_data. With RD_LAT=0 the write occurs in the accept cycle.
- i_stop is latched as stop_pending in any non-IDLE state and cleared on entry to IDLE. i_stop in IDLE is ignored.
- i_start outside IDLE is ignored.
- i_sof and an accept in the same cycle of WAIT_SOF/WAIT_FULL: the SOF transition takes effect and the pixel is discarded. The first pixel counted is the first accept after SOF.
- Errors are sticky until reset or the next i_start.
- o_rd_bank changes only in the o_frame_done cycle, so the reader never sees a partial frame.
- The count register is AW bits wide. Its compare uses the constant H_RES*V_RES evaluated at AW bits; wrap cannot occur.

Decomposition:
- Shared package (cam_pkg): the FSM state encoding (IDLE, WAIT_CAM, WAIT_SOF, CAPTURE, FRAME_END, WAIT_FULL) and FRAME_PIX = H_RES*V_RES.
- One natural sub-module, cam_wr_pipe: the RD_LAT-deep valid/address delay line with a flush input.

Test Plan:
1. H_RES=4, V_RES=2, RD_LAT=1. Reset, then i_start with i_cam_done=0 for 20 cycles -> o_data_ready=0, o_busy=1, no o_wr_en.
2. Same config, i_cam_done=1, SOF, then 8 continuous pixels 0x001..0x008 -> writes to bank 0, addr 0..7, data matching. One cycle after the last write, o_frame_done pulses, o_rd_bank=0, o_wr_bank=1.
3. Continuous mode, 3 frames -> banks written 0,1,0. o_rd_bank sequence 0,1,0. Exactly 3 o_frame_done pulses.
4. SOF after 5 pixels -> o_err_short=1. The next frame writes addr 0..7 in the same bank, and o_frame_done fires once.
5. Snapshot=1: after a frame, 3 extra pixels before SOF -> FSM returns to IDLE and o_data_ready=0. Repeat with snapshot=0 in WAIT_FULL -> o_err_long=1.
6. Reset asserted at pixel 4 of CAPTURE -> all outputs 0 on the next cycle, and no o_wr_en from pipelined pixels. RD_LAT=2 run of scenario 2 -> writes delayed by 2 cycles, same addresses and data.
